dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's memory stage. It answers every MEM-stage access (address, write data, write enable) with same-cycle read data for the MEM/WB register. It backs a word-addressed data RAM and a small memory-mapped output port. Words stored to the TX address are buffered in a FIFO and drained by an external consumer through a valid/ready handshake, for example to stream RSA results off-chip.

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: word RAM with zero-latency loads plus a
// memory-mapped TX FIFO (data + status/overflow) drained by a valid/ready consumer.
module dmem_responder #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadData,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [29:0]   TX_WORD     = IO_BASE[31:2];
   localparam logic [29:0]   STATUS_WORD = IO_BASE[31:2] + 30'd1;
   localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

   // ---------------------------------------------------------------- decode
   logic          sel_ram;
   logic          sel_tx;
   logic          sel_status;
   logic [AW-1:0] ram_idx;

   assign sel_ram    = (ALUOutM < IO_BASE);
   assign sel_tx     = (ALUOutM[31:2] == TX_WORD);
   assign sel_status = (ALUOutM[31:2] == STATUS_WORD);
   assign ram_idx    = ALUOutM[AW+1:2];

   // ---------------------------------------------------------------- data RAM
   logic [31:0] ram_q [DEPTH];

   // NOTE: storage arrays carry no reset; contents survive reset and map to plain RAM.
   always_ff @(posedge clk) begin
      if (MemWriteM && sel_ram) begin
         ram_q[ram_idx] <= WriteDataM;
      end
   end

   // ---------------------------------------------------------------- TX FIFO
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic empty;
   logic full;
   logic pop;
   logic tx_store;
   logic push;
   logic ovf_set;
   logic ovf_clr;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_COUNT);
   assign pop      = tx_valid & tx_ready;
   assign tx_store = MemWriteM & sel_tx;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign push     = tx_store & (~full | pop);
   assign ovf_set  = tx_store & full & ~pop;
   assign ovf_clr  = MemWriteM & sel_status & WriteDataM[2];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= WriteDataM;
      end
   end

   assign tx_valid = ~empty;
   // Gated so the head reads as zero while empty, including straight out of reset.
   assign tx_data  = tx_valid ? fifo_q[rd_ptr_q] : '0;

   // ---------------------------------------------------------------- load path
   logic [31:0] status_word;

   always_comb begin
      status_word       = '0;
      status_word[0]    = empty;
      status_word[1]    = full;
      status_word[2]    = ovf_q;
      status_word[15:8] = 8'(count_q);
   end

   always_comb begin
      ReadData = '0;
      if (sel_ram) begin
         ReadData = ram_q[ram_idx];
      end else if (sel_status) begin
         ReadData = status_word;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// run against a queue/array reference model.
module tb_dmem_responder;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned FD      = 8;
   localparam logic [31:0] IO_BASE = 32'h0000_1000;
   localparam logic [31:0] TX_A    = IO_BASE;
   localparam logic [31:0] ST_A    = IO_BASE + 32'd4;

   logic        clk;
   logic        reset;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadData;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .IO_BASE(IO_BASE)) dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
      .WriteDataM(WriteDataM), .ReadData(ReadData), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference model
   logic [31:0] ram_m [DEPTH];
   bit          ram_v [DEPTH];
   logic [31:0] fifo_m [$];
   bit          ov_m;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (a < IO_BASE) begin
         r = ram_m[(a >> 2) % DEPTH];
      end else if ((a >> 2) == (ST_A >> 2)) begin
         r[0]    = (fifo_m.size() == 0);
         r[1]    = (fifo_m.size() == FD);
         r[2]    = ov_m;
         r[15:8] = 8'(fifo_m.size());
      end
      return r;
   endfunction

   task automatic model_commit();
      int n;
      bit pop, txst, clr, set;
      int idx;
      n    = fifo_m.size();
      pop  = (n > 0) && tx_ready;
      txst = MemWriteM && ((ALUOutM >> 2) == (TX_A >> 2));
      clr  = MemWriteM && ((ALUOutM >> 2) == (ST_A >> 2)) && WriteDataM[2];
      set  = 1'b0;
      if (MemWriteM && (ALUOutM < IO_BASE)) begin
         idx = int'((ALUOutM >> 2) % DEPTH);
         ram_m[idx] = WriteDataM;
         ram_v[idx] = 1'b1;
      end
      if (pop) void'(fifo_m.pop_front());
      if (txst) begin
         if (n < FD || pop) fifo_m.push_back(WriteDataM);
         else set = 1'b1;
      end
      ov_m = set | (ov_m & ~clr);
   endtask

   task automatic apply(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
      MemWriteM  = we;
      ALUOutM    = a;
      WriteDataM = d;
      tx_ready   = rdy;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         apply(1'b0, ST_A, 32'd0, 1'b1);
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      apply(1'b0, ST_A, 32'd0, 1'b0);
      reset = 1'b0;
      #3;
      vec_cnt++;
      if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
      vec_cnt++;
      if (tx_data !== 32'd0) begin err_cnt++; $display("FAIL reset_tx_data: got %h, expected 0", tx_data); end
      vec_cnt++;
      if (ReadData !== 32'h0000_0001) begin err_cnt++; $display("FAIL reset_status: got %h, expected 00000001", ReadData); end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_ram();
      apply(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      tick();
      apply(1'b0, 32'h10, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL ram_load: got %h, expected deadbeef", ReadData); end
      apply(1'b0, 32'h10 + 4 * DEPTH, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL ram_alias: got %h, expected deadbeef", ReadData); end
      apply(1'b0, 32'h12, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL ram_byte_offset: got %h, expected deadbeef", ReadData); end
      apply(1'b1, 32'h10, 32'h1111_2222, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL ram_same_cycle_old: got %h, expected deadbeef", ReadData); end
      tick();
      apply(1'b0, 32'h10, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h1111_2222) begin err_cnt++; $display("FAIL ram_overwrite: got %h, expected 11112222", ReadData); end
   endtask

   task automatic test_tx_stream();
      for (int k = 1; k <= 3; k++) begin
         apply(1'b1, TX_A, 32'(k), 1'b0);
         if (k == 1) begin
            vec_cnt++;
            if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL tx_no_fallthrough: got %b, expected 0", tx_valid); end
            vec_cnt++;
            if (ReadData !== 32'd0) begin err_cnt++; $display("FAIL tx_load_zero: got %h, expected 0", ReadData); end
         end
         tick();
      end
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0300) begin err_cnt++; $display("FAIL tx_status3: got %h, expected 00000300", ReadData); end
      for (int k = 1; k <= 3; k++) begin
         apply(1'b0, ST_A, 32'd0, 1'b1);
         vec_cnt++;
         if (tx_valid !== 1'b1 || tx_data !== 32'(k))
         begin err_cnt++; $display("FAIL tx_stream_word: got v=%b d=%h, expected v=1 d=%h", tx_valid, tx_data, 32'(k)); end
         tick();
      end
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL tx_drained_valid: got %b, expected 0", tx_valid); end
      vec_cnt++;
      if (ReadData !== 32'h0000_0001) begin err_cnt++; $display("FAIL tx_drained_status: got %h, expected 00000001", ReadData); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= FD; i++) begin
         apply(1'b1, TX_A, 32'h100 + 32'(i), 1'b0);
         tick();
      end
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0806) begin err_cnt++; $display("FAIL ovf_status: got %h, expected 00000806", ReadData); end
      apply(1'b1, ST_A, 32'h4, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0806) begin err_cnt++; $display("FAIL ovf_pre_edge: got %h, expected 00000806", ReadData); end
      tick();
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0802) begin err_cnt++; $display("FAIL ovf_cleared: got %h, expected 00000802", ReadData); end
      for (int i = 0; i < FD; i++) begin
         apply(1'b0, ST_A, 32'd0, 1'b1);
         vec_cnt++;
         if (tx_valid !== 1'b1 || tx_data !== 32'h100 + 32'(i))
         begin err_cnt++; $display("FAIL ovf_drain_word: got v=%b d=%h, expected v=1 d=%h", tx_valid, tx_data, 32'h100 + 32'(i)); end
         tick();
      end
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_ninth_dropped: got %b, expected 0", tx_valid); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp;
      for (int i = 0; i < FD; i++) begin
         apply(1'b1, TX_A, 32'h200 + 32'(i), 1'b0);
         tick();
      end
      apply(1'b1, TX_A, 32'hA5, 1'b1);
      vec_cnt++;
      if (tx_data !== 32'h200) begin err_cnt++; $display("FAIL full_pp_head: got %h, expected 00000200", tx_data); end
      tick();
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0802) begin err_cnt++; $display("FAIL full_pp_status: got %h, expected 00000802", ReadData); end
      for (int i = 0; i < FD; i++) begin
         exp = (i < FD - 1) ? 32'h201 + 32'(i) : 32'hA5;
         apply(1'b0, ST_A, 32'd0, 1'b1);
         vec_cnt++;
         if (tx_valid !== 1'b1 || tx_data !== exp)
         begin err_cnt++; $display("FAIL full_pp_order: got v=%b d=%h, expected v=1 d=%h", tx_valid, tx_data, exp); end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, TX_A, 32'h400 + 32'(i), 1'b0);
         tick();
      end
      apply(1'b1, 32'hC, 32'd7, 1'b0);
      tick();
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (tx_valid !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_valid: got %b, expected 1", tx_valid); end
      #1 reset = 1'b0;
      #1;
      vec_cnt++;
      if (tx_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_async_valid: got %b, expected 0", tx_valid); end
      vec_cnt++;
      if (ReadData !== 32'h0000_0001) begin err_cnt++; $display("FAIL rst_status: got %h, expected 00000001", ReadData); end
      apply(1'b0, 32'hC, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'd7) begin err_cnt++; $display("FAIL rst_ram_kept: got %h, expected 00000007", ReadData); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      fifo_m.delete();
      ov_m = 1'b0;
   endtask

   task automatic test_unmapped();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, TX_A, 32'h300 + 32'(i), 1'b0);
         tick();
      end
      apply(1'b1, IO_BASE + 32'd8, 32'h0000_FFFF, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'd0) begin err_cnt++; $display("FAIL unmap_store_cycle: got %h, expected 0", ReadData); end
      tick();
      apply(1'b0, IO_BASE + 32'd8, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'd0) begin err_cnt++; $display("FAIL unmap_load: got %h, expected 0", ReadData); end
      apply(1'b0, ST_A, 32'd0, 1'b0);
      vec_cnt++;
      if (ReadData !== 32'h0000_0200) begin err_cnt++; $display("FAIL unmap_fifo_intact: got %h, expected 00000200", ReadData); end
      vec_cnt++;
      if (tx_data !== 32'h300) begin err_cnt++; $display("FAIL unmap_head: got %h, expected 00000300", tx_data); end
      drain(2);
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp;
      bit          we, rdy;
      int          kind;
      for (int i = 0; i < 3000; i++) begin
         kind = int'($urandom_range(0, 9));
         we   = ($urandom_range(0, 1) == 1);
         d    = $urandom;
         if (kind <= 3 || kind >= 8)
            a = 32'($urandom_range(0, 3)) * 32'(4 * DEPTH) + (32'($urandom_range(0, 15)) << 2)
                + 32'($urandom_range(0, 3));
         else if (kind <= 5) begin a = TX_A + 32'($urandom_range(0, 3)); we = ($urandom_range(0, 3) != 0); end
         else if (kind == 6) a = ST_A;
         else a = IO_BASE + 32'd8 + (32'($urandom_range(0, 63)) << 2);
         if ((i % 256) < 128) rdy = ($urandom_range(0, 7) == 0);
         else rdy = ($urandom_range(0, 1) == 1);
         apply(we, a, d, rdy);
         if (a >= IO_BASE || ram_v[(a >> 2) % DEPTH]) begin
            exp = model_read(a);
            vec_cnt++;
            if (ReadData !== exp) begin err_cnt++; $display("FAIL rnd_read @%h: got %h, expected %h", a, ReadData, exp); end
         end
         vec_cnt++;
         if (tx_valid !== (fifo_m.size() > 0))
         begin err_cnt++; $display("FAIL rnd_valid: got %b, expected %b", tx_valid, fifo_m.size() > 0); end
         if (fifo_m.size() > 0) begin
            vec_cnt++;
            if (tx_data !== fifo_m[0]) begin err_cnt++; $display("FAIL rnd_head: got %h, expected %h", tx_data, fifo_m[0]); end
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ram_v[i] = 1'b0;
      ov_m       = 1'b0;
      MemWriteM  = 1'b0;
      ALUOutM    = '0;
      WriteDataM = '0;
      tx_ready   = 1'b0;
      test_reset();
      test_ram();
      test_tx_stream();
      test_overflow();
      test_full_push_pop();
      test_reset_midstream();
      test_unmapped();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
